// File: rtl/cmd_pack_pkg.sv
// Shared constants, FSM type and CRC step for the SPI command-frame transmitter.
package cmd_pack_pkg;

  localparam logic [15:0] FRAME_HEADER  = 16'hEB90;
  localparam int          PAYLOAD_BYTES = 42;
  localparam int          FRAME_BITS    = 368;
  localparam int          CRC_FIRST     = 16;
  localparam int          CRC_START     = CRC_FIRST + PAYLOAD_BYTES * 8;
  localparam logic [15:0] CRC_POLY      = 16'h1021;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] c,
    input logic        d
  );
    return {c[14:0], 1'b0} ^ ((c[15] ^ d) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_ccitt_serial.sv
// Bit-serial CRC-16/CCITT-FALSE accumulator, one data bit per en pulse.
import cmd_pack_pkg::*;

module crc16_ccitt_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      crc <= CRC_INIT;
    else if (init)
      crc <= CRC_INIT;
    else if (en)
      crc <= crc16_step(crc, din);
  end

endmodule

// File: rtl/cmd_pack_tx.sv
// SPI command-frame transmitter: header, 42 payload bytes, CRC-16, then idle gap.
// Optional CMD_PACK_ERR_INJECT_EN adds inject_crc_err to corrupt the sent CRC.
import cmd_pack_pkg::*;

module cmd_pack_tx #(
  parameter int CLK_DIV  = 4,
  parameter int GAP_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [31:0] ftw_lower_1,
  input  logic [31:0] ftw_upper_1,
  input  logic [31:0] ftw_lower_2,
  input  logic [31:0] ftw_upper_2,
  input  logic [31:0] sweep_step,
  input  logic [15:0] sweep_rate,
  input  logic [15:0] pulse_period,
  input  logic [15:0] resweep_period,
  input  logic [2:0]  mode,
  input  logic        rf_switch,
  input  logic [5:0]  tx_att,
  input  logic [7:0]  rx_ch1_att,
  input  logic [7:0]  rx_ch2_att,
  input  logic [7:0]  rx_ch3_att,
  input  logic [7:0]  rx_ch1_pha,
  input  logic [7:0]  rx_ch2_pha,
  input  logic [7:0]  rx_ch3_pha,
  input  logic [31:0] ct_period,
  input  logic [31:0] ys_period,
  output logic        busy,
  output logic        done,
  output logic        spi_sclk,
  output logic        spi_din
`ifdef CMD_PACK_ERR_INJECT_EN
  ,
  input  logic        inject_crc_err
`endif
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int GW = $clog2(GAP_BITS * 2 * CLK_DIV + 1);

  state_t                  state;
  logic [FRAME_BITS-1:0]   sreg;
  logic [FRAME_BITS-1:0]   frame;
  logic [8:0]              idx;
  logic [8:0]              nidx;
  logic [PW-1:0]           ph;
  logic [GW-1:0]           gcnt;
  logic                    accept;
  logic                    bit_end;
  logic                    crc_en;
  logic [15:0]             crc;
  logic [15:0]             tx_crc;

  assign frame = {
    FRAME_HEADER,
    ftw_lower_1, ftw_upper_1,
    ftw_lower_2, ftw_upper_2,
    sweep_step,
    sweep_rate, pulse_period, resweep_period,
    mode, rf_switch, 4'b0000,
    2'b00, tx_att,
    rx_ch1_att, rx_ch2_att, rx_ch3_att,
    rx_ch1_pha, rx_ch2_pha, rx_ch3_pha,
    ct_period, ys_period,
    16'h0000
  };

  assign accept  = (state == IDLE) && send;
  assign bit_end = (state == SHIFT) && (ph == PW'(2 * CLK_DIV - 1));
  assign nidx    = idx + 9'd1;
  assign crc_en  = bit_end &&
                   (nidx >= 9'(CRC_FIRST)) &&
                   (nidx < 9'(CRC_START));

  // The current bit always sits in the top of the shift register.
  assign spi_din = (state == SHIFT) && sreg[FRAME_BITS-1];

`ifdef CMD_PACK_ERR_INJECT_EN
  logic inj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      inj <= 1'b0;
    else if (accept)
      inj <= inject_crc_err;
  end

  assign tx_crc = {crc[15:1], crc[0] ^ inj};
`else
  assign tx_crc = crc;
`endif

  crc16_ccitt_serial u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (accept),
    .en   (crc_en),
    .din  (sreg[FRAME_BITS-2]),
    .crc  (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      idx      <= '0;
      ph       <= '0;
      gcnt     <= '0;
      spi_sclk <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (send) begin
            state    <= SHIFT;
            sreg     <= frame;
            idx      <= '0;
            ph       <= '0;
            spi_sclk <= 1'b0;
            busy     <= 1'b1;
          end
        end
        SHIFT: begin
          ph <= ph + 1'b1;
          if (ph == PW'(CLK_DIV - 1))
            spi_sclk <= 1'b1;
          if (bit_end) begin
            ph       <= '0;
            spi_sclk <= 1'b0;
            if (idx == 9'(FRAME_BITS - 1)) begin
              state <= GAP;
              gcnt  <= '0;
            end else if (nidx == 9'(CRC_START)) begin
              // CRC is frozen here and loaded into the zero tail.
              sreg[FRAME_BITS-1 -: 16] <= tx_crc;
              idx <= nidx;
            end else begin
              sreg <= sreg << 1;
              idx  <= nidx;
            end
          end
        end
        GAP: begin
          gcnt <= gcnt + 1'b1;
          if (gcnt == GW'(GAP_BITS * 2 * CLK_DIV - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
